toggle_counter: RTL and testbench

- Downstream consumer of the T flip-flop output `q`.
- Counts toggles (edges) of `q` over a programmable window of `clk` cycles, then reports the count with a one-cycle valid pulse.
- Used to measure TFF toggle rate and divided frequency in the same clock domain as the flip-flop.

---
 rtl/toggle_counter_pkg.sv | 14 +
 rtl/toggle_counter_edge_detect.sv | 28 ++
 rtl/toggle_counter.sv | 103 ++++++++++
 tb/tb_toggle_counter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/toggle_counter_pkg.sv
// Shared types and default parameters for the toggle_counter measurement block.
// TOGGLE_COUNTER_RISE_ONLY_EN (in edge_detect) selects rising-edge-only counting.
package toggle_counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } tc_state_t;

  localparam int unsigned TC_CNT_W_DEF   = 8;
  localparam int unsigned TC_WIN_LEN_DEF = 16;

endpackage

// File: rtl/toggle_counter_edge_detect.sv
// Edge detector on the measured TFF output; remembers the previous sample every cycle.
// TOGGLE_COUNTER_RISE_ONLY_EN: count rising edges only, otherwise both edges.
module edge_detect
  import toggle_counter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic edge_c
);

  logic q_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_prev_q <= 1'b0;
    end else begin
      q_prev_q <= d;
    end
  end

`ifdef TOGGLE_COUNTER_RISE_ONLY_EN
  assign edge_c = d & ~q_prev_q;
`else
  assign edge_c = d ^ q_prev_q;
`endif

endmodule

// File: rtl/toggle_counter.sv
// Counts edges of q_in over a WIN_LEN-cycle window and reports the saturating count.
// Edge polarity is selected by TOGGLE_COUNTER_RISE_ONLY_EN inside edge_detect.
module toggle_counter
  import toggle_counter_pkg::*;
#(
  parameter int unsigned CNT_W   = TC_CNT_W_DEF,
  parameter int unsigned WIN_LEN = TC_WIN_LEN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q_in,
  input  logic             start,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             overflow
);

  localparam int unsigned      WIN_W    = $clog2(WIN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);

  tc_state_t        state_q;
  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] win_d;
  logic [CNT_W-1:0] acc_q;
  logic [CNT_W-1:0] acc_d;
  logic             ovf_q;
  logic             valid_q;
  logic             busy_q;
  logic             edge_c;

  edge_detect u_edge_detect (
    .clk    (clk),
    .rst    (rst),
    .d      (q_in),
    .edge_c (edge_c)
  );

  assign win_d = win_q + WIN_W'(1);
  assign acc_d = acc_q + CNT_W'(1);

  // Window FSM; a start in DONE re-arms directly so windows run back-to-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= COUNT;
            win_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        COUNT: begin
          if (edge_c) begin
            if (acc_q == CNT_MAX) begin
              ovf_q <= 1'b1;
            end else begin
              acc_q <= acc_d;
            end
          end
          win_q <= win_d;
          if (win_q == WIN_LAST) begin
            state_q <= DONE;
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          valid_q <= 1'b0;
          if (start) begin
            state_q <= COUNT;
            win_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign count       = acc_q;
  assign count_valid = valid_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_toggle_counter.sv
// Bench for toggle_counter: three instances (8/16, 3/16, 8/1) share stimulus and are
// compared every cycle against a window-arithmetic reference model over sampled q_in history.
module tb_toggle_counter;

  localparam int ND = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       q_in;
  logic       start;
  logic       busy_a, cv_a, ov_a;
  logic [7:0] cnt_a;
  logic       busy_b, cv_b, ov_b;
  logic [2:0] cnt_b;
  logic       busy_c, cv_c, ov_c;
  logic [7:0] cnt_c;

  toggle_counter #(.CNT_W(8), .WIN_LEN(16)) dut_a (
    .clk(clk), .rst(rst), .q_in(q_in), .start(start),
    .busy(busy_a), .count(cnt_a), .count_valid(cv_a), .overflow(ov_a)
  );
  toggle_counter #(.CNT_W(3), .WIN_LEN(16)) dut_b (
    .clk(clk), .rst(rst), .q_in(q_in), .start(start),
    .busy(busy_b), .count(cnt_b), .count_valid(cv_b), .overflow(ov_b)
  );
  toggle_counter #(.CNT_W(8), .WIN_LEN(1)) dut_c (
    .clk(clk), .rst(rst), .q_in(q_in), .start(start),
    .busy(busy_c), .count(cnt_c), .count_valid(cv_c), .overflow(ov_c)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: q_in sampled at every edge since reset, one window per instance.
  bit qs [8192];
  int cyc;
  int WL [ND] = '{16, 16, 1};
  int MX [ND] = '{255, 7, 255};
  bit active [ND];
  int last_k [ND];

  int per = 0;
  int tgl = 0;
  bit rnd = 0;

  int ob [ND];
  int ocv [ND];
  int oov [ND];
  int ocnt [ND];

  typedef struct {
    int per;
    int c8;
    int o8;
    int c3;
    int o3;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int edges_in(input int k, input int c);
    int n = 0;
    for (int i = k + 1; i <= c; i++) begin
`ifdef TOGGLE_COUNTER_RISE_ONLY_EN
      if (qs[i] && !qs[i-1]) n++;
`else
      if (qs[i] != qs[i-1]) n++;
`endif
    end
    return n;
  endfunction

  task automatic grab();
    ob[0] = int'(busy_a); ocv[0] = int'(cv_a); oov[0] = int'(ov_a); ocnt[0] = int'(cnt_a);
    ob[1] = int'(busy_b); ocv[1] = int'(cv_b); oov[1] = int'(ov_b); ocnt[1] = int'(cnt_b);
    ob[2] = int'(busy_c); ocv[2] = int'(cv_c); oov[2] = int'(ov_c); ocnt[2] = int'(cnt_c);
  endtask

  task automatic model_check();
    int n, e;
    grab();
    for (int d = 0; d < ND; d++) begin
      n = 0;
      if (active[d]) begin
        e = (cyc < last_k[d] + WL[d]) ? cyc : last_k[d] + WL[d];
        n = edges_in(last_k[d], e);
      end
      chk($sformatf("busy%0d", d), ob[d], int'(active[d] && cyc <= last_k[d] + WL[d]));
      chk($sformatf("valid%0d", d), ocv[d], int'(active[d] && cyc == last_k[d] + WL[d]));
      chk($sformatf("count%0d", d), ocnt[d], (n > MX[d]) ? MX[d] : n);
      chk($sformatf("ovf%0d", d), oov[d], int'(n > MX[d]));
    end
  endtask

  // One clock: drive q_in at negedge, sample at posedge, check 1 time unit later.
  task automatic tick();
    if (rnd) q_in = 1'($urandom_range(0, 1));
    else if (per != 0) begin
      if (tgl == per - 1) begin
        q_in = ~q_in;
        tgl = 0;
      end else tgl++;
    end
    @(posedge clk);
    cyc++;
    qs[cyc] = q_in;
    for (int d = 0; d < ND; d++)
      if (start && (!active[d] || cyc > last_k[d] + WL[d])) begin
        active[d] = 1'b1;
        last_k[d] = cyc;
      end
    #1;
    model_check();
    @(negedge clk);
  endtask

  task automatic model_reset();
    cyc = 0;
    qs[0] = 1'b0;
    for (int d = 0; d < ND; d++) begin
      active[d] = 1'b0;
      last_k[d] = 0;
    end
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    grab();
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst_busy%0d", d), ob[d], 0);
      chk($sformatf("rst_valid%0d", d), ocv[d], 0);
      chk($sformatf("rst_count%0d", d), ocnt[d], 0);
      chk($sformatf("rst_ovf%0d", d), oov[d], 0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run_vec(input int idx);
    int lat;
    bit seen;
    per = tbl[idx].per;
    tgl = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      tick();
      lat++;
      seen = cv_a;
    end
    chk($sformatf("v%0d_seen", idx), int'(seen), 1);
    chk($sformatf("v%0d_latency", idx), lat, 16);
    chk($sformatf("v%0d_cnt8", idx), int'(cnt_a), tbl[idx].c8);
    chk($sformatf("v%0d_ovf8", idx), int'(ov_a), tbl[idx].o8);
    chk($sformatf("v%0d_cnt3", idx), int'(cnt_b), tbl[idx].c3);
    chk($sformatf("v%0d_ovf3", idx), int'(ov_b), tbl[idx].o3);
    tick();
    tick();
  endtask

  initial begin
    int pulses, idle, seen;
`ifdef TOGGLE_COUNTER_RISE_ONLY_EN
    tbl[0] = '{1, 8, 0, 7, 1};
    tbl[1] = '{0, 0, 0, 0, 0};
    tbl[2] = '{2, 4, 0, 4, 0};
    tbl[3] = '{4, 2, 0, 2, 0};
    tbl[4] = '{8, 1, 0, 1, 0};
`else
    tbl[0] = '{1, 16, 0, 7, 1};
    tbl[1] = '{0, 0, 0, 0, 0};
    tbl[2] = '{2, 8, 0, 7, 1};
    tbl[3] = '{4, 4, 0, 4, 0};
    tbl[4] = '{8, 2, 0, 2, 0};
`endif
    rst = 1'b1;
    q_in = 1'b0;
    start = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    grab();
    chk("init_busy", ob[0], 0);
    chk("init_count", ocnt[0], 0);
    chk("init_valid", ocv[0], 0);
    chk("init_ovf", oov[0], 0);
    @(negedge clk);
    rst = 1'b0;

    // q_in toggling while idle must not move the count.
    per = 1;
    repeat (20) tick();
    chk("idle_count", int'(cnt_a), 0);
    chk("idle_busy", int'(busy_a), 0);

    for (int i = 0; i < 5; i++) run_vec(i);

    // Start held high: windows chain with no idle cycle.
    per = 1;
    start = 1'b1;
    pulses = 0;
    idle = 0;
    tick();
    for (int i = 0; i < 52; i++) begin
      tick();
      if (cv_a) pulses++;
      if (!busy_a) idle++;
    end
    start = 1'b0;
    chk("b2b_pulses", pulses, 3);
    chk("b2b_idle", idle, 0);
    repeat (20) tick();

    // Reset during window cycle 5: window abandoned, no result pulse.
    per = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    do_reset();
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (cv_a || cv_b || cv_c) seen++;
    end
    chk("rst_no_valid", seen, 0);
    chk("rst_idle_busy", int'(busy_a), 0);
    run_vec(0);

    // Random q_in and start, all instances against the model.
    rnd = 1'b1;
    for (int i = 0; i < 800; i++) begin
      start = ($urandom_range(0, 7) == 0);
      tick();
    end
    start = 1'b0;
    rnd = 1'b0;
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
